// File: rtl/fifo_axis_reader.sv
// Drains a registered-output synchronous FIFO into an AXI4-Stream master through a
// 2-entry skid buffer, framing the stream with TLAST every FRAME_LEN beats.
module fifo_axis_reader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAME_LEN  = 160,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  FIFO_EMPTY,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_EN,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY,
  output logic [CNT_W-1:0]      FRAME_CNT,
  output logic                  BUSY
);

  localparam int unsigned          BEAT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BEAT_W-1:0]    BEAT_LAST = BEAT_W'(FRAME_LEN - 1);

  logic [1:0]            occ_q, occ_d;
  logic                  infl_q, infl_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  last_q, last_d;

  logic                  pop;
  logic [1:0]            occ_after_pop;
  logic [2:0]            occ_sum;

  always_comb begin
    pop           = (occ_q != 2'd0) & M_AXIS_TREADY;
    occ_after_pop = occ_q - {1'b0, pop};
    occ_sum       = {1'b0, occ_after_pop} + {2'b00, infl_q};
    // Read ahead only if the word would still fit after this cycle's pop.
    RD_EN         = ~ARESET & ~FIFO_EMPTY & (occ_sum < 3'd2);
    infl_d        = RD_EN;
    occ_d         = occ_sum[1:0];

    head_d = head_q;
    tail_d = tail_q;
    if (pop && (occ_q == 2'd2)) head_d = tail_q;
    if (infl_q) begin
      if (occ_after_pop == 2'd0) head_d = RD_DATA;
      else                       tail_d = RD_DATA;
    end

    beat_d      = beat_q;
    frame_cnt_d = frame_cnt_q;
    if (pop) begin
      if (beat_q == BEAT_LAST) begin
        beat_d      = '0;
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
    end
    last_d = (occ_d != 2'd0) && (beat_d == BEAT_LAST);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      occ_q       <= '0;
      infl_q      <= 1'b0;
      beat_q      <= '0;
      frame_cnt_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      last_q      <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      infl_q      <= infl_d;
      beat_q      <= beat_d;
      frame_cnt_q <= frame_cnt_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      last_q      <= last_d;
    end
  end

  assign M_AXIS_TDATA  = head_q;
  assign M_AXIS_TVALID = (occ_q != 2'd0);
  assign M_AXIS_TLAST  = last_q;
  assign FRAME_CNT     = frame_cnt_q;
  assign BUSY          = (occ_q != 2'd0) | infl_q;

  occ_overflow_chk: assert property (@(posedge ACLK) disable iff (ARESET) occ_sum <= 3'd2);

endmodule
